// File: rtl/tdm_pkg.sv
// Shared types and sizing helpers for the tdm_demux8 serial demultiplexer.
package tdm_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        PAR  = 2'd2
    } tdm_state_e;

    localparam int TDM_NCH_DEFAULT = 8;

    // The slot index must stay at least 1 bit wide, even for tiny channel counts.
    function automatic int tdm_slot_w(input int nch);
        return (nch > 1) ? $clog2(nch) : 1;
    endfunction

endpackage

// File: rtl/tdm_slot_ctr.sv
// Slot counter for the TDM demultiplexer. It supports clear, load-to-1, wrap and
// increment, and it flags the terminal slot.
module tdm_slot_ctr import tdm_pkg::*; #(
    parameter  int NCH    = TDM_NCH_DEFAULT,
    localparam int SLOT_W = tdm_slot_w(NCH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_clear,
    input  logic              i_load1,
    input  logic              i_wrap,
    input  logic              i_inc,
    output logic [SLOT_W-1:0] o_slot,
    output logic              o_last
);

    logic [SLOT_W-1:0] r_slot;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)       r_slot <= '0;
        else if (i_clear) r_slot <= '0;
        else if (i_load1) r_slot <= SLOT_W'(1);
        else if (i_wrap)  r_slot <= '0;
        else if (i_inc)   r_slot <= r_slot + SLOT_W'(1);
    end

    assign o_slot = r_slot;
    assign o_last = (r_slot == SLOT_W'(NCH - 1));

endmodule

// File: rtl/tdm_demux8.sv
// Serial TDM demultiplexer. It collects NCH slot bits per sync-marked frame and
// presents each completed frame as a registered word. Defining TDM_PARITY_EN adds
// an even-parity beat after every frame.
module tdm_demux8 import tdm_pkg::*; #(
    parameter  int NCH    = TDM_NCH_DEFAULT,
    localparam int SLOT_W = tdm_slot_w(NCH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              din,
    input  logic              valid,
    input  logic              sync,
    output logic [NCH-1:0]    dout,
    output logic              frame_valid,
    output logic              sync_err,
    output logic              parity_err,
    output logic [SLOT_W-1:0] slot
);

    tdm_state_e        r_state, w_next;
    logic [NCH-1:0]    r_shift, r_dout, w_asm;
    logic [SLOT_W-1:0] w_slot;
    logic              w_last, w_clear, w_load1, w_wrap, w_inc;
    logic              w_restart, w_store, w_frame, w_serr;
    logic              r_frame_valid, r_sync_err;

    tdm_slot_ctr #(.NCH(NCH)) u_slot_ctr (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_clear (w_clear),
        .i_load1 (w_load1),
        .i_wrap  (w_wrap),
        .i_inc   (w_inc),
        .o_slot  (w_slot),
        .o_last  (w_last)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: if (valid && sync) w_next = RUN;
            RUN: begin
                if (valid && !sync) begin
                    if (w_slot == '0) w_next = IDLE;
`ifdef TDM_PARITY_EN
                    else if (w_last)  w_next = PAR;
`endif
                end
            end
`ifdef TDM_PARITY_EN
            PAR:     if (valid) w_next = RUN;
`endif
            default: w_next = IDLE;
        endcase
    end

`ifdef TDM_PARITY_EN
    logic w_perr;
`endif

    always_comb begin
        w_clear   = 1'b0;
        w_load1   = 1'b0;
        w_wrap    = 1'b0;
        w_inc     = 1'b0;
        w_restart = 1'b0;
        w_store   = 1'b0;
        w_frame   = 1'b0;
        w_serr    = 1'b0;
`ifdef TDM_PARITY_EN
        w_perr    = 1'b0;
`endif
        case (r_state)
            IDLE: begin
                w_load1   = valid && sync;
                w_restart = valid && sync;
            end
            RUN: begin
                if (valid) begin
                    if (sync) begin
                        w_load1   = 1'b1;
                        w_restart = 1'b1;
                        w_serr    = (w_slot != '0);
                    end else if (w_slot == '0) begin
                        w_serr    = 1'b1;
                        w_clear   = 1'b1;
                    end else begin
                        w_store   = 1'b1;
                        w_wrap    = w_last;
                        w_inc     = !w_last;
`ifndef TDM_PARITY_EN
                        w_frame   = w_last;
`endif
                    end
                end
            end
`ifdef TDM_PARITY_EN
            PAR: begin
                if (valid) begin
                    if (sync) begin
                        w_serr    = 1'b1;
                        w_load1   = 1'b1;
                        w_restart = 1'b1;
                    end else begin
                        w_frame   = 1'b1;
                        w_perr    = (^r_shift) ^ din;
                    end
                end
            end
`endif
            default: ;
        endcase
    end

    // The final data beat is merged here so that dout can load on the same edge that samples it.
    always_comb begin
        w_asm = r_shift;
        if (r_state == RUN) w_asm[w_slot] = din;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)         r_shift <= '0;
        else if (w_restart) r_shift <= {{(NCH-1){1'b0}}, din};
        else if (w_store)   r_shift[w_slot] <= din;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_dout        <= '0;
            r_frame_valid <= 1'b0;
            r_sync_err    <= 1'b0;
        end else begin
            r_frame_valid <= w_frame;
            r_sync_err    <= w_serr;
            if (w_frame) r_dout <= w_asm;
        end
    end

`ifdef TDM_PARITY_EN
    logic r_parity_err;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_parity_err <= 1'b0;
        else        r_parity_err <= w_perr;
    end
    assign parity_err = r_parity_err;
`else
    assign parity_err = 1'b0;
`endif

    assign dout        = r_dout;
    assign frame_valid = r_frame_valid;
    assign sync_err    = r_sync_err;
    assign slot        = w_slot;

endmodule
